mips_cpu_muldiv: RTL and testbench
==================================

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO register width in bits (WIDTH >= 4, even).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on a rising edge while busy=0.
REQ-005 op  input  3  operation: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000 and 111 mean no operation.
REQ-006 rs_content  input  WIDTH  multiplicand or dividend; MTHI/MTLO source.
REQ-007 rt_content  input  WIDTH  multiplier or divisor.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking the end of MULT, MULTU, DIV or DIVU.
REQ-010 div_by_zero  output  1  one-cycle pulse, coincident with done, when the divisor was 0.
REQ-011 hi  output  WIDTH  registered HI.
REQ-012 lo  output  WIDTH  registered LO.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and FIX; the operation is accepted on edge E0 when start=1, busy=0 and op is valid.
REQ-014 Operand and opcode values SHALL be latched at E0; later changes on the inputs SHALL have no effect on the operation.
REQ-015 MULT, MULTU, DIV and DIVU (nonzero divisor) SHALL go IDLE->CALC at E0, run radix-2 iterations on edges E1..E_WIDTH, then CALC->FIX->IDLE at E_WIDTH+1.
REQ-016 busy SHALL be 1 from after E0 until E_WIDTH+1; hi, lo and done=1 SHALL be updated at E_WIDTH+1, giving a latency of WIDTH+1 cycles.
REQ-017 MULT and MULTU SHALL produce the full 2*WIDTH-bit product with {hi,lo}=product; MULT treats operands as two's complement, MULTU as unsigned.
REQ-018 DIV and DIVU SHALL write the quotient to lo and the remainder to hi.
REQ-019 Signed division SHALL truncate the quotient toward zero and give the remainder the sign of the dividend; signs are fixed up in FIX.
REQ-020 DIV of the most-negative value by -1 SHALL give lo=most-negative value and hi=0, with no error flag.
REQ-021 DIV or DIVU with rt_content=0 SHALL not enter CALC; at E1, done=1 and div_by_zero=1, hi and lo are unchanged, and busy stays 0.
REQ-022 MTHI and MTLO SHALL write rs_content to hi or lo respectively at E0, with no busy and no done.
REQ-023 start while busy=1 SHALL be ignored, including MTHI and MTLO.
REQ-024 start with op 000 or 111 SHALL be ignored.
REQ-025 done and div_by_zero SHALL be 0 in every cycle other than the completion cycle.
REQ-026 A new start in the cycle where done=1 SHALL be accepted, since busy=0 in that cycle.

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0 and lo=0.
REQ-028 reset asserted during CALC or FIX SHALL abort the operation and discard partial results; no done pulse SHALL follow.

Configuration
REQ-029 With MULDIV_FAST_MUL_EN defined, MULT and MULTU SHALL use a single-cycle multiplier: hi, lo and done=1 at E1, and busy stays 0.
REQ-030 Without MULDIV_FAST_MUL_EN, MULT and MULTU SHALL be iterative per REQ-015 and REQ-016.
REQ-031 Division behaviour SHALL be identical with or without MULDIV_FAST_MUL_EN.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE and lo=0x00000001, done exactly 33 cycles after E0, busy high for 33 cycles (macro off).
REQ-033 MULT -3 x 5 -> hi=0xFFFFFFFF and lo=0xFFFFFFF1; with the macro on -> same values with done at E1.
REQ-034 DIV -7/2 -> lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU 7/2 -> lo=3 and hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 and hi=0.
REQ-035 DIVU 5/0 with prior hi=0x11, lo=0x22 -> at E1 done=1 and div_by_zero=1, hi=0x11 and lo=0x22 unchanged, busy never 1.
REQ-036 MTHI 0xABCD0000 during a busy MULT is ignored; the MULT result is then written; a subsequent MTHI 0xABCD0000 when idle -> hi=0xABCD0000 at the next edge.
REQ-037 reset pulsed 10 cycles into a DIVU -> busy=0, hi=lo=0 immediately, and no done pulse afterwards.

Source files
------------

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply/divide unit: iterative radix-2 MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle one.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand, hi_q, lo_q;
  logic [CW-1:0]        cnt;
  logic                 is_div_q, neg_q, neg_r;
  logic                 done_q, dz_q, dz_pend, fm_pend;

  logic                 accept, op_mul, op_div, op_sgn, a_neg, b_neg, div_zero, iter_go;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH-1:0]     mul_add;
  logic [WIDTH:0]       mul_sum, div_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  assign accept   = start & ~busy;
  assign op_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div   = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_sgn   = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg    = op_sgn & rs_content[WIDTH-1];
  assign b_neg    = op_sgn & rt_content[WIDTH-1];
  assign abs_a    = a_neg ? -rs_content : rs_content;
  assign abs_b    = b_neg ? -rt_content : rt_content;
  assign div_zero = (rt_content == '0);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = (op == OP_MULT)
    ? {{WIDTH{rs_content[WIDTH-1]}}, rs_content} * {{WIDTH{rt_content[WIDTH-1]}}, rt_content}
    : {{WIDTH{1'b0}}, rs_content} * {{WIDTH{1'b0}}, rt_content};
  assign iter_go = accept & op_div & ~div_zero;
`else
  assign iter_go = accept & ((op_div & ~div_zero) | op_mul);
`endif

  // Both datapaths work on magnitudes; signs are restored in FIX.
  // Multiply: acc = {partial, multiplier}, shift right with carry-in of the add.
  assign mul_add  = acc[0] ? mcand : {WIDTH{1'b0}};
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}, shift left.
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
  assign div_step = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign fix_lo   = is_div_q ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod_fix[WIDTH-1:0];
  assign fix_hi   = is_div_q ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                             : prod_fix[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iter_go) state_d = CALC;
      CALC:    if (cnt == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      dz_pend  <= 1'b0;
      fm_pend  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      dz_pend <= 1'b0;
      fm_pend <= 1'b0;
      // Deferred one-cycle completions for divide-by-zero and the fast multiplier.
      if (dz_pend) begin
        done_q <= 1'b1;
        dz_q   <= 1'b1;
      end
      if (fm_pend) begin
        hi_q   <= acc[2*WIDTH-1:WIDTH];
        lo_q   <= acc[WIDTH-1:0];
        done_q <= 1'b1;
      end
      if (state_q == CALC) begin
        acc <= is_div_q ? div_step : mul_step;
        cnt <= cnt + 1'b1;
      end else if (state_q == FIX) begin
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
        done_q <= 1'b1;
      end else if (iter_go) begin
        acc      <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
        mcand    <= op_div ? abs_b : abs_a;
        cnt      <= '0;
        is_div_q <= op_div;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (accept && op_mul) begin
        acc     <= fast_prod;
        fm_pend <= 1'b1;
      end
`endif
      else if (accept && op_div && div_zero) begin
        dz_pend <= 1'b1;
      end
      // Moves are younger than any pending fast-multiply write, so they win.
      if (accept && op == OP_MTHI) hi_q <= rs_content;
      if (accept && op == OP_MTLO) lo_q <= rs_content;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed table, random ops against an arithmetic model,
// and hand sequences for busy-ignore, no-op, and mid-operation reset.
module tb_mips_cpu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] rs_content = '0, rt_content = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0, errors = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_content(rs_content), .rt_content(rt_content),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, e_hi, e_lo;
    logic         e_dz;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definitions.
  task automatic ref_model(input logic [2:0] o, input logic [W-1:0] a, b, cur_hi, cur_lo,
                           output logic [W-1:0] e_hi, e_lo, output logic e_dz);
    int sa, sb;
    longint sp;
    logic [63:0] p;
    sa = a; sb = b;
    e_hi = cur_hi; e_lo = cur_lo; e_dz = 1'b0;
    case (o)
      3'b001: begin sp = longint'(sa) * longint'(sb); p = sp; e_hi = p[63:32]; e_lo = p[31:0]; end
      3'b010: begin p = {32'b0, a} * {32'b0, b}; e_hi = p[63:32]; e_lo = p[31:0]; end
      3'b011: begin
        if (b == 0) e_dz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e_lo = a; e_hi = 0; end
        else begin e_lo = sa / sb; e_hi = sa % sb; end
      end
      3'b100: begin
        if (b == 0) e_dz = 1'b1;
        else begin e_lo = a / b; e_hi = a % b; end
      end
      3'b101: e_hi = a;
      3'b110: e_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, b, e_hi, e_lo,
                        input logic e_dz, input string name);
    int lat, bcnt, e_lat, e_busy;
    @(negedge clk);
    start = 1'b1; op = o; rs_content = a; rt_content = b;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the unit must use latched values.
    start = 1'b0; op = 3'($urandom); rs_content = $urandom; rt_content = $urandom;
    if (o == 3'b101 || o == 3'b110) begin
      chk({name, " mv hi"}, hi, e_hi);
      chk({name, " mv lo"}, lo, e_lo);
      chk({name, " mv busy"}, busy, 0);
    end else begin
      if ((o == 3'b011 || o == 3'b100) && b == 0) e_lat = 1;
`ifdef MULDIV_FAST_MUL_EN
      else if (o == 3'b001 || o == 3'b010) e_lat = 1;
`endif
      else e_lat = W + 1;
      e_busy = (e_lat == 1) ? 0 : W + 1;
      lat = 0; bcnt = busy ? 1 : 0;
      do begin
        @(posedge clk); #1;
        lat++;
        if (busy) bcnt++;
      end while (!done && lat < 100);
      chk({name, " latency"}, lat, e_lat);
      chk({name, " busy cycles"}, bcnt, e_busy);
      chk({name, " hi"}, hi, e_hi);
      chk({name, " lo"}, lo, e_lo);
      chk({name, " dz"}, div_by_zero, e_dz);
    end
    m_hi = e_hi; m_lo = e_lo;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'($urandom_range(1, 15));
      2: return -W'($urandom_range(1, 15));
      3: case ($urandom_range(0, 2))
           0: return 32'h8000_0000;
           1: return 32'h7FFF_FFFF;
           default: return 32'hFFFF_FFFF;
         endcase
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b, eh, el;
    logic         ed;
    int           n, dcnt;

    tbl[0]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1]  = '{3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    tbl[2]  = '{3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3]  = '{3'b100, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    tbl[4]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[5]  = '{3'b011, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[6]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[7]  = '{3'b101, 32'h0000_0011, 32'h0000_0000, 32'h0000_0011, 32'h0000_0000, 1'b0};
    tbl[8]  = '{3'b110, 32'h0000_0022, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b0};
    tbl[9]  = '{3'b100, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1};
    tbl[10] = '{3'b011, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1};
    tbl[11] = '{3'b010, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // Reset state
    #2 reset = 1'b1;
    #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dz", div_by_zero, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e_hi, tbl[i].e_lo, tbl[i].e_dz,
             $sformatf("vec%0d", i));

    // Random ops issued back to back (next start lands in the done cycle).
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(1, 6));
      a = rnd_val(); b = rnd_val();
      ref_model(o, a, b, m_hi, m_lo, eh, el, ed);
      run_op(o, a, b, eh, el, ed, $sformatf("rnd%0d op%0d", i, o));
    end

    // op 000 / 111 ignored; done must not linger after completion
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs_content = 32'hDEAD_BEEF; rt_content = 32'h1;
    @(negedge clk); op = 3'b111;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("noop busy", busy, 0);
    chk("noop done", done, 0);
    chk("noop hi", hi, m_hi);
    chk("noop lo", lo, m_lo);

`ifndef MULDIV_FAST_MUL_EN
    // MTHI during a busy MULT is dropped
    @(negedge clk);
    start = 1'b1; op = 3'b001; rs_content = 32'd3; rt_content = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b101; rs_content = 32'hABCD_0000;
    @(posedge clk); #1; start = 1'b0;
    chk("busy mthi still busy", busy, 1);
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("busy mthi done seen", done, 1);
    chk("busy mthi hi", hi, 0);
    chk("busy mthi lo", lo, 12);
    m_hi = 0; m_lo = 12;
`endif
    run_op(3'b101, 32'hABCD_0000, 32'h0, 32'hABCD_0000, m_lo, 1'b0, "idle mthi");

    // Reset 10 cycles into a DIVU
    run_op(3'b110, 32'h1234_5678, 32'h0, m_hi, 32'h1234_5678, 1'b0, "pre-reset mtlo");
    @(negedge clk);
    start = 1'b1; op = 3'b100; rs_content = 32'd1000; rt_content = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    @(negedge clk); reset = 1'b0;
    dcnt = 0;
    repeat (50) begin @(posedge clk); #1; if (done) dcnt++; end
    chk("abort no done", dcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
